// File: rtl/color_defs.sv
// Shared colour codes, FSM state encoding and LED decode for the colour pipeline.
package color_defs;

  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;

  // Width of the consecutive-match counter (CONFIRM_N up to 15)
  localparam int MATCH_W = 4;
  // Width of the hold timer (HOLD_CYCLES up to 2^20-1)
  localparam int HOLD_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_t;

  // One-hot LED pattern {b, g, r} for a colour code; NONE lights nothing.
  function automatic logic [2:0] color_to_led(input logic [1:0] c);
    logic [2:0] led;
    case (c)
      COLOR_RED:   led = 3'b001;
      COLOR_GREEN: led = 3'b010;
      COLOR_BLUE:  led = 3'b100;
      default:     led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  // Tally register: clear wins, otherwise count up and stick at the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_ZERO;
    end else if (clr) begin
      count <= CNT_ZERO;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/color_confirm_fsm.sv
// Debounces detected colour codes: a colour is accepted only after CONFIRM_N
// identical consecutive non-zero samples, then it is shown on the LEDs for
// HOLD_CYCLES clocks and counted in a saturating per-colour tally.
module color_confirm_fsm
  import color_defs::*;
#(
  parameter int CONFIRM_N   = 3,
  parameter int HOLD_CYCLES = 1000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic [1:0]       color,
  input  logic             color_valid,
  input  logic             clear_counts,
  output logic [1:0]       confirmed_color,
  output logic             color_event,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             busy,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] green_count,
  output logic [CNT_W-1:0] blue_count
);

  localparam logic [MATCH_W-1:0] CONFIRM_TARGET = MATCH_W'(CONFIRM_N);
  // Timer counts down to zero, so the LED is lit for HOLD_LOAD+1 cycles
  localparam logic [HOLD_W-1:0]  HOLD_LOAD      = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO      = {HOLD_W{1'b0}};
  localparam logic [MATCH_W-1:0] MATCH_ZERO     = {MATCH_W{1'b0}};
  localparam logic [MATCH_W-1:0] MATCH_ONE      = MATCH_W'(1);

  fsm_state_t         state;
  logic [1:0]         candidate;
  logic [MATCH_W-1:0] match_cnt;
  logic [HOLD_W-1:0]  hold_timer;

  fsm_state_t         next_state;
  logic [1:0]         next_cand;
  logic [MATCH_W-1:0] next_match;
  logic               confirm;

  logic               inc_r;
  logic               inc_g;
  logic               inc_b;

  // Tracking decode: next candidate/match count and whether this strobe confirms
  always_comb begin
    next_state = state;
    next_cand  = candidate;
    next_match = match_cnt;
    confirm    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (color_valid && (color != COLOR_NONE)) begin
          next_cand  = color;
          next_match = MATCH_ONE;
          if (MATCH_ONE == CONFIRM_TARGET) begin
            confirm = 1'b1;
          end else begin
            next_state = ST_TRACK;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (!color_valid) begin
          next_state = ST_TRACK;
        end else if (color == COLOR_NONE) begin
          next_state = ST_IDLE;
          next_cand  = COLOR_NONE;
          next_match = MATCH_ZERO;
        end else if (color == candidate) begin
          next_match = match_cnt + MATCH_ONE;
          confirm    = (next_match == CONFIRM_TARGET);
        end else begin
          next_cand  = color;
          next_match = MATCH_ONE;
          confirm    = (MATCH_ONE == CONFIRM_TARGET);
        end
      end
      ST_HOLD: begin
        // Strobes are ignored while the LED is held
        next_state = ST_HOLD;
      end
      default: begin
        next_state = ST_IDLE;
        next_cand  = COLOR_NONE;
        next_match = MATCH_ZERO;
      end
    endcase
  end

  // Main FSM: confirmation, hold timing and all registered indicator outputs
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      candidate       <= COLOR_NONE;
      match_cnt       <= MATCH_ZERO;
      hold_timer      <= HOLD_ZERO;
      confirmed_color <= COLOR_NONE;
      color_event     <= 1'b0;
      led_r           <= 1'b0;
      led_g           <= 1'b0;
      led_b           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      color_event <= 1'b0;
      if (confirm) begin
        state                 <= ST_HOLD;
        candidate             <= next_cand;
        match_cnt             <= next_match;
        hold_timer            <= HOLD_LOAD;
        color_event           <= 1'b1;
        confirmed_color       <= next_cand;
        {led_b, led_g, led_r} <= color_to_led(next_cand);
        busy                  <= 1'b1;
      end else if (state == ST_HOLD) begin
        if (hold_timer == HOLD_ZERO) begin
          state     <= ST_IDLE;
          candidate <= COLOR_NONE;
          match_cnt <= MATCH_ZERO;
          led_r     <= 1'b0;
          led_g     <= 1'b0;
          led_b     <= 1'b0;
          busy      <= 1'b0;
        end else begin
          hold_timer <= hold_timer - HOLD_W'(1);
        end
      end else begin
        state     <= next_state;
        candidate <= next_cand;
        match_cnt <= next_match;
      end
    end
  end

  assign inc_r = confirm && (next_cand == COLOR_RED);
  assign inc_g = confirm && (next_cand == COLOR_GREEN);
  assign inc_b = confirm && (next_cand == COLOR_BLUE);

  sat_counter #(.W(CNT_W)) u_red_cnt (
    .clk   (clk_1MHz),
    .rst_n (rst_n),
    .inc   (inc_r),
    .clr   (clear_counts),
    .count (red_count)
  );

  sat_counter #(.W(CNT_W)) u_green_cnt (
    .clk   (clk_1MHz),
    .rst_n (rst_n),
    .inc   (inc_g),
    .clr   (clear_counts),
    .count (green_count)
  );

  sat_counter #(.W(CNT_W)) u_blue_cnt (
    .clk   (clk_1MHz),
    .rst_n (rst_n),
    .inc   (inc_b),
    .clr   (clear_counts),
    .count (blue_count)
  );

endmodule

// File: tb/tb_color_confirm_fsm.sv
// Directed bench for color_confirm_fsm with an event scoreboard.
`timescale 1ns/1ps
module tb_color_confirm_fsm;
  import color_defs::*;

  localparam int CONFIRM_N   = 3;
  localparam int HOLD_CYCLES = 10;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk_1MHz = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       color = 2'd0;
  logic             color_valid = 1'b0;
  logic             clear_counts = 1'b0;
  logic [1:0]       confirmed_color;
  logic             color_event;
  logic             led_r;
  logic             led_g;
  logic             led_b;
  logic             busy;
  logic [CNT_W-1:0] red_count;
  logic [CNT_W-1:0] green_count;
  logic [CNT_W-1:0] blue_count;

  typedef struct {
    logic [1:0]       col;
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] g;
    logic [CNT_W-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_r = 0;
  int   m_g = 0;
  int   m_b = 0;
  int   lit;

  color_confirm_fsm #(
    .CONFIRM_N   (CONFIRM_N),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_1MHz        (clk_1MHz),
    .rst_n           (rst_n),
    .color           (color),
    .color_valid     (color_valid),
    .clear_counts    (clear_counts),
    .confirmed_color (confirmed_color),
    .color_event     (color_event),
    .led_r           (led_r),
    .led_g           (led_g),
    .led_b           (led_b),
    .busy            (busy),
    .red_count       (red_count),
    .green_count     (green_count),
    .blue_count      (blue_count)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tally update for one confirmation, pushed to the scoreboard
  task automatic exp_confirm(input logic [1:0] c, input bit clr);
    exp_t e;
    if (clr) begin
      m_r = 0; m_g = 0; m_b = 0;
    end else if (c == COLOR_RED) begin
      if (m_r < CNT_MAX) m_r++;
    end else if (c == COLOR_GREEN) begin
      if (m_g < CNT_MAX) m_g++;
    end else begin
      if (m_b < CNT_MAX) m_b++;
    end
    e.col = c;
    e.r = CNT_W'(m_r);
    e.g = CNT_W'(m_g);
    e.b = CNT_W'(m_b);
    sb.push_back(e);
  endtask

  // One-cycle strobe; returns on the negedge right after the sampling edge
  task automatic strobe(input logic [1:0] c, input bit clr);
    @(negedge clk_1MHz);
    color        = c;
    color_valid  = 1'b1;
    clear_counts = clr;
    @(negedge clk_1MHz);
    color_valid  = 1'b0;
    color        = 2'd0;
    clear_counts = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk_1MHz);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b0) break;
      @(negedge clk_1MHz);
    end
    chk("idle_timeout", busy, 0);
    @(negedge clk_1MHz);
  endtask

  // Three matching strobes; the last one confirms
  task automatic confirm3(input logic [1:0] c, input bit clr_last);
    strobe(c, 1'b0); gap();
    strobe(c, 1'b0); gap();
    chk("pre_confirm_noev", color_event, 0);
    exp_confirm(c, clr_last);
    strobe(c, clr_last);
    chk("confirm_ev", color_event, 1);
    @(negedge clk_1MHz);
    chk("confirm_ev_one_cycle", color_event, 0);
    wait_idle();
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_r"}, red_count, m_r);
    chk({tag, "_g"}, green_count, m_g);
    chk({tag, "_b"}, blue_count, m_b);
  endtask

  // Scoreboard: every event must match the oldest pending expectation
  always @(negedge clk_1MHz) begin
    exp_t       e;
    logic [2:0] l;
    if (rst_n === 1'b1 && color_event === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        l = 3'b001 << (e.col - 2'd1);
        chk("ev_color", confirmed_color, e.col);
        chk("ev_leds", {led_b, led_g, led_r}, l);
        chk("ev_busy", busy, 1);
        chk("ev_red_count", red_count, e.r);
        chk("ev_green_count", green_count, e.g);
        chk("ev_blue_count", blue_count, e.b);
      end
    end
  end

  initial begin
    #(100000 * 1000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk_1MHz);
    chk("rst_color", confirmed_color, 0);
    chk("rst_event", color_event, 0);
    chk("rst_leds", {led_b, led_g, led_r}, 0);
    chk("rst_busy", busy, 0);
    check_counts("rst_cnt");
    rst_n = 1'b1;
    @(negedge clk_1MHz);

    // 1,1,1 confirms red with one-cycle latency
    strobe(COLOR_RED, 1'b0); gap();
    chk("r1_noev", color_event, 0);
    strobe(COLOR_RED, 1'b0); gap();
    chk("r2_noev", color_event, 0);
    exp_confirm(COLOR_RED, 1'b0);
    strobe(COLOR_RED, 1'b0);
    chk("r3_ev", color_event, 1);
    chk("r3_color", confirmed_color, 1);
    chk("r3_led_r", led_r, 1);
    chk("r3_red_count", red_count, 1);
    @(negedge clk_1MHz);
    chk("r3_ev_drop", color_event, 0);
    wait_idle();

    // 2,2,3,3,3 confirms blue only
    strobe(COLOR_GREEN, 1'b0); gap();
    strobe(COLOR_GREEN, 1'b0);
    chk("gg_noev", color_event, 0);
    gap();
    strobe(COLOR_BLUE, 1'b0); gap();
    strobe(COLOR_BLUE, 1'b0); gap();
    exp_confirm(COLOR_BLUE, 1'b0);
    strobe(COLOR_BLUE, 1'b0);
    chk("bbb_ev", color_event, 1);
    chk("bbb_color", confirmed_color, 3);
    chk("bbb_blue_count", blue_count, 1);
    chk("bbb_green_count", green_count, 0);
    wait_idle();

    // 1,1,0,1,1 gives nothing; a further 1 confirms
    strobe(COLOR_RED, 1'b0); gap();
    strobe(COLOR_RED, 1'b0); gap();
    strobe(COLOR_NONE, 1'b0); gap();
    strobe(COLOR_RED, 1'b0); gap();
    strobe(COLOR_RED, 1'b0);
    chk("restart_noev", color_event, 0);
    chk("restart_busy", busy, 0);
    gap();
    exp_confirm(COLOR_RED, 1'b0);
    strobe(COLOR_RED, 1'b0);
    chk("restart_ev", color_event, 1);
    chk("restart_red_count", red_count, 2);
    wait_idle();

    // Hold length and strobes ignored during HOLD
    strobe(COLOR_GREEN, 1'b0); gap();
    strobe(COLOR_GREEN, 1'b0); gap();
    exp_confirm(COLOR_GREEN, 1'b0);
    strobe(COLOR_GREEN, 1'b0);
    lit = 0;
    for (int k = 0; k < 30; k++) begin
      if (led_g !== 1'b1) break;
      lit++;
      color       = COLOR_GREEN;
      color_valid = ((k % 3) == 1);
      @(negedge clk_1MHz);
    end
    color_valid = 1'b0;
    color       = 2'd0;
    chk("hold_len", lit, HOLD_CYCLES);
    chk("hold_busy_drop", busy, 0);
    chk("hold_color_kept", confirmed_color, 2);
    gap();
    strobe(COLOR_GREEN, 1'b0); gap();
    strobe(COLOR_GREEN, 1'b0);
    chk("post_hold_noev", color_event, 0);
    gap();
    exp_confirm(COLOR_GREEN, 1'b0);
    strobe(COLOR_GREEN, 1'b0);
    chk("post_hold_ev", color_event, 1);
    wait_idle();

    // Clear, then saturation: red reads 1,2,3,3,3
    @(negedge clk_1MHz);
    clear_counts = 1'b1;
    @(negedge clk_1MHz);
    clear_counts = 1'b0;
    m_r = 0; m_g = 0; m_b = 0;
    check_counts("clr1");
    chk("clr1_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      confirm3(COLOR_RED, 1'b0);
      chk("sat_red", red_count, (i < CNT_MAX) ? i + 1 : CNT_MAX);
    end
    @(negedge clk_1MHz);
    clear_counts = 1'b1;
    @(negedge clk_1MHz);
    clear_counts = 1'b0;
    m_r = 0; m_g = 0; m_b = 0;
    check_counts("clr2");

    // Clear coinciding with a confirm: clear wins, event still fires
    confirm3(COLOR_GREEN, 1'b0);
    confirm3(COLOR_RED, 1'b1);
    check_counts("clr_coincide");

    // Reset in the middle of HOLD
    strobe(COLOR_BLUE, 1'b0); gap();
    strobe(COLOR_BLUE, 1'b0); gap();
    exp_confirm(COLOR_BLUE, 1'b0);
    strobe(COLOR_BLUE, 1'b0);
    repeat (3) @(negedge clk_1MHz);
    chk("midhold_led_b_before", led_b, 1);
    #200;
    rst_n = 1'b0;
    #1;
    m_r = 0; m_g = 0; m_b = 0;
    chk("midhold_leds", {led_b, led_g, led_r}, 0);
    chk("midhold_busy", busy, 0);
    chk("midhold_event", color_event, 0);
    check_counts("midhold_cnt");
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
    strobe(COLOR_BLUE, 1'b0); gap();
    strobe(COLOR_BLUE, 1'b0);
    chk("post_rst_noev", color_event, 0);
    chk("post_rst_busy", busy, 0);
    gap();
    exp_confirm(COLOR_BLUE, 1'b0);
    strobe(COLOR_BLUE, 1'b0);
    chk("post_rst_ev", color_event, 1);
    chk("post_rst_blue_count", blue_count, 1);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
